// File: rtl/synth_pkg.sv
// Shared types and helpers for the polyphonic voice controller.
package synth_pkg;

  localparam int KEY_W = 7;
  localparam int SAT_W = 128;

  typedef enum logic [1:0] {
    V_IDLE    = 2'd0,
    V_ATTACK  = 2'd1,
    V_SUSTAIN = 2'd2,
    V_RELEASE = 2'd3
  } voice_state_e;

  typedef enum logic {
    S_WAIT  = 1'b0,
    S_APPLY = 1'b1
  } ev_state_e;

  // 2'b01: above the signed out_w range, 2'b10: below it, 2'b00: fits.
  function automatic logic [1:0] sat_dir(input logic signed [SAT_W-1:0] v, input int out_w);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = SAT_W'(1);
    hi  = (one <<< (out_w - 1)) - one;
    lo  = -hi - one;
    if (v > hi) return 2'b01;
    if (v < lo) return 2'b10;
    return 2'b00;
  endfunction

endpackage

// File: rtl/synth_voice.sv
// One square-wave voice: envelope state machine, level, phase counter and polarity.
module synth_voice
  import synth_pkg::*;
#(
  parameter int AMP_W  = 31,
  parameter int HALF_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    load_clear,
  input  logic                    release_req,
  input  logic [KEY_W-1:0]        key_in,
  input  logic [HALF_W-1:0]       half_in,
  input  logic [AMP_W-1:0]        amplitude,
  input  logic [AMP_W-1:0]        attack_step,
  input  logic [AMP_W-1:0]        release_step,
  output voice_state_e            state,
  output logic [KEY_W-1:0]        key,
  output logic signed [AMP_W:0]   sample
);

  voice_state_e       state_q, state_d;
  logic [AMP_W-1:0]   level_q, level_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [HALF_W-1:0]  half_q, half_d;
  logic [HALF_W-1:0]  phase_q, phase_d;
  logic               neg_q, neg_d;

  logic [AMP_W:0]     att_sum;
  logic [AMP_W-1:0]   att_lvl;
  logic [AMP_W-1:0]   rel_lvl;
  logic signed [AMP_W:0] mag;

  // Attack sum is one bit wider so a large step cannot wrap past amplitude.
  assign att_sum = {1'b0, level_q} + {1'b0, attack_step};
  assign att_lvl = (att_sum > {1'b0, amplitude}) ? amplitude : att_sum[AMP_W-1:0];
  assign rel_lvl = (level_q > release_step) ? (level_q - release_step) : '0;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    key_d   = key_q;
    half_d  = half_q;
    phase_d = phase_q;
    neg_d   = neg_q;
    if (load) begin
      state_d = V_ATTACK;
      key_d   = key_in;
      half_d  = half_in;
      phase_d = '0;
      neg_d   = 1'b0;
      if (load_clear) level_d = '0;
    end else begin
      if (half_q == '0) begin
        phase_d = '0;
      end else if (phase_q == half_q - HALF_W'(1)) begin
        phase_d = '0;
        neg_d   = ~neg_q;
      end else begin
        phase_d = phase_q + HALF_W'(1);
      end
      case (state_q)
        V_ATTACK: begin
          if (release_req) begin
            state_d = V_RELEASE;
          end else begin
            level_d = att_lvl;
            if (att_lvl == amplitude) state_d = V_SUSTAIN;
          end
        end
        V_SUSTAIN: begin
          if (release_req) state_d = V_RELEASE;
          else             level_d = amplitude;
        end
        V_RELEASE: begin
          level_d = rel_lvl;
          if (rel_lvl == '0) state_d = V_IDLE;
        end
        default: level_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= V_IDLE;
      level_q <= '0;
      key_q   <= '0;
      half_q  <= '0;
      phase_q <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      key_q   <= key_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      neg_q   <= neg_d;
    end
  end

  assign mag    = {1'b0, level_q};
  assign sample = (half_q == '0) ? '0 : (neg_q ? -mag : mag);
  assign state  = state_q;
  assign key    = key_q;

endmodule

// File: rtl/poly_voice_controller.sv
// Event handshake, voice allocation/stealing and saturating mixer over NUM_VOICES voices.
module poly_voice_controller
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AMP_W      = 31,
  parameter int HALF_W     = 16,
  parameter int OUT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic                  ev_on,
  input  logic [KEY_W-1:0]      ev_key,
  input  logic [HALF_W-1:0]     ev_half_period,
  input  logic [AMP_W-1:0]      amplitude,
  input  logic [AMP_W-1:0]      attack_step,
  input  logic [AMP_W-1:0]      release_step,
  output logic [NUM_VOICES-1:0] active_mask,
  output logic [OUT_W-1:0]      wave_out
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SUM_W = AMP_W + 1 + $clog2(NUM_VOICES);

  ev_state_e          ev_state_q, ev_state_d;
  logic               ev_on_q, ev_on_d;
  logic [KEY_W-1:0]   ev_key_q, ev_key_d;
  logic [HALF_W-1:0]  ev_half_q, ev_half_d;
  logic [IDX_W-1:0]   steal_ptr_q, steal_ptr_d;
  logic [OUT_W-1:0]   wave_q, wave_d;

  voice_state_e          v_state  [NUM_VOICES];
  logic [KEY_W-1:0]      v_key    [NUM_VOICES];
  logic signed [AMP_W:0] v_sample [NUM_VOICES];

  logic [NUM_VOICES-1:0] key_hit, held_hit, load, load_clear, rel_req;
  logic                  idle_any;
  logic [IDX_W-1:0]      idle_idx;
  logic signed [SUM_W-1:0] mix_sum;
  logic signed [SAT_W-1:0] mix_wide;
  logic [1:0]              mix_sat;

  assign ev_ready = reset && (ev_state_q == S_WAIT);

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    synth_voice #(
      .AMP_W  (AMP_W),
      .HALF_W (HALF_W)
    ) u_voice (
      .clk          (clk),
      .reset        (reset),
      .load         (load[gi]),
      .load_clear   (load_clear[gi]),
      .release_req  (rel_req[gi]),
      .key_in       (ev_key_q),
      .half_in      (ev_half_q),
      .amplitude    (amplitude),
      .attack_step  (attack_step),
      .release_step (release_step),
      .state        (v_state[gi]),
      .key          (v_key[gi]),
      .sample       (v_sample[gi])
    );
    assign key_hit[gi]     = (v_state[gi] != V_IDLE) && (v_key[gi] == ev_key_q);
    assign held_hit[gi]    = ((v_state[gi] == V_ATTACK) || (v_state[gi] == V_SUSTAIN)) &&
                             (v_key[gi] == ev_key_q);
    assign active_mask[gi] = (v_state[gi] != V_IDLE);
  end

  always_comb begin
    ev_state_d = ev_state_q;
    ev_on_d    = ev_on_q;
    ev_key_d   = ev_key_q;
    ev_half_d  = ev_half_q;
    case (ev_state_q)
      S_WAIT: begin
        if (ev_valid) begin
          ev_on_d    = ev_on;
          ev_key_d   = ev_key;
          ev_half_d  = ev_half_period;
          ev_state_d = S_APPLY;
        end
      end
      default: ev_state_d = S_WAIT;
    endcase
  end

  // Allocation priority: retrigger same key, then lowest idle voice, then steal.
  always_comb begin
    load        = '0;
    load_clear  = '0;
    rel_req     = '0;
    steal_ptr_d = steal_ptr_q;
    idle_any    = 1'b0;
    idle_idx    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (v_state[i] == V_IDLE) begin
        idle_any = 1'b1;
        idle_idx = IDX_W'(i);
      end
    end
    if (ev_state_q == S_APPLY) begin
      if (ev_on_q) begin
        if (|key_hit) begin
          load = key_hit;
        end else if (idle_any) begin
          load[idle_idx]       = 1'b1;
          load_clear[idle_idx] = 1'b1;
        end else begin
          load[steal_ptr_q]       = 1'b1;
          load_clear[steal_ptr_q] = 1'b1;
          steal_ptr_d = (steal_ptr_q == IDX_W'(NUM_VOICES - 1)) ? '0 : steal_ptr_q + IDX_W'(1);
        end
      end else begin
        rel_req = held_hit;
      end
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mix_sum = mix_sum + SUM_W'(v_sample[i]);
    end
    mix_wide = SAT_W'(mix_sum);
    mix_sat  = sat_dir(mix_wide, OUT_W);
    case (mix_sat)
      2'b01:   wave_d = {1'b0, {(OUT_W - 1){1'b1}}};
      2'b10:   wave_d = {1'b1, {(OUT_W - 1){1'b0}}};
      default: wave_d = mix_wide[OUT_W-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ev_state_q  <= S_WAIT;
      ev_on_q     <= 1'b0;
      ev_key_q    <= '0;
      ev_half_q   <= '0;
      steal_ptr_q <= '0;
      wave_q      <= '0;
    end else begin
      ev_state_q  <= ev_state_d;
      ev_on_q     <= ev_on_d;
      ev_key_q    <= ev_key_d;
      ev_half_q   <= ev_half_d;
      steal_ptr_q <= steal_ptr_d;
      wave_q      <= wave_d;
    end
  end

  assign wave_out = wave_q;

endmodule

// File: tb/tb_poly_voice_controller.sv
// Randomized and directed bench for poly_voice_controller against a behavioural voice model.
module tb_poly_voice_controller;

  localparam int NV     = 4;
  localparam int AMP_W  = 31;
  localparam int HALF_W = 16;
  localparam int OUT_W  = 32;
  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINN = -64'sd2147483648;
  localparam int IDLE = 0, ATT = 1, SUS = 2, REL = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ev_valid = 1'b0;
  logic              ev_on = 1'b0;
  logic [6:0]        ev_key = '0;
  logic [HALF_W-1:0] ev_half_period = '0;
  logic [AMP_W-1:0]  amplitude = '0;
  logic [AMP_W-1:0]  attack_step = '0;
  logic [AMP_W-1:0]  release_step = '0;
  logic              ev_ready;
  logic [NV-1:0]     active_mask;
  logic [OUT_W-1:0]  wave_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  poly_voice_controller #(
    .NUM_VOICES (NV),
    .AMP_W      (AMP_W),
    .HALF_W     (HALF_W),
    .OUT_W      (OUT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_on          (ev_on),
    .ev_key         (ev_key),
    .ev_half_period (ev_half_period),
    .amplitude      (amplitude),
    .attack_step    (attack_step),
    .release_step   (release_step),
    .active_mask    (active_mask),
    .wave_out       (wave_out)
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-voice state, level, key, half-period and the edge at which it was loaded.
  int     m_st   [NV];
  longint m_lvl  [NV];
  int     m_key  [NV];
  int     m_half [NV];
  longint m_load [NV];
  bit     m_pend = 1'b0;
  bit     m_on;
  int     m_k, m_h;
  int     m_ptr = 0;
  longint m_wave = 0;
  longint n_edges = 0;

  always @(posedge clk) begin : model
    longint s, k, amp, as, rs;
    bit     busy [NV];
    bit     hit;
    int     tgt;
    amp = longint'(amplitude);
    as  = longint'(attack_step);
    rs  = longint'(release_step);
    if (!reset) begin
      for (int i = 0; i < NV; i++) begin
        m_st[i] = IDLE; m_lvl[i] = 0; m_key[i] = 0; m_half[i] = 0; m_load[i] = 0;
      end
      m_pend = 1'b0;
      m_ptr  = 0;
      m_wave = 0;
    end else begin
      s = 0;
      for (int i = 0; i < NV; i++) begin
        if (m_half[i] != 0) begin
          k = n_edges - m_load[i];
          if (((k / m_half[i]) % 2) == 0) s += m_lvl[i];
          else                             s -= m_lvl[i];
        end
      end
      m_wave = (s > MAXP) ? MAXP : ((s < MINN) ? MINN : s);
      for (int i = 0; i < NV; i++) busy[i] = 1'b0;
      if (m_pend) begin
        m_pend = 1'b0;
        if (m_on) begin
          hit = 1'b0;
          for (int i = 0; i < NV; i++) begin
            if (m_st[i] != IDLE && m_key[i] == m_k) begin
              hit = 1'b1;
              m_st[i] = ATT; m_half[i] = m_h; m_load[i] = n_edges + 1; busy[i] = 1'b1;
            end
          end
          if (!hit) begin
            tgt = -1;
            for (int i = NV - 1; i >= 0; i--) if (m_st[i] == IDLE) tgt = i;
            if (tgt < 0) begin
              tgt   = m_ptr;
              m_ptr = (m_ptr + 1) % NV;
            end
            m_st[tgt] = ATT; m_key[tgt] = m_k; m_half[tgt] = m_h; m_lvl[tgt] = 0;
            m_load[tgt] = n_edges + 1; busy[tgt] = 1'b1;
          end
        end else begin
          for (int i = 0; i < NV; i++) begin
            if ((m_st[i] == ATT || m_st[i] == SUS) && m_key[i] == m_k) begin
              m_st[i] = REL; busy[i] = 1'b1;
            end
          end
        end
      end else if (ev_valid) begin
        m_pend = 1'b1; m_on = ev_on; m_k = int'(ev_key); m_h = int'(ev_half_period);
      end
      for (int i = 0; i < NV; i++) begin
        if (!busy[i]) begin
          case (m_st[i])
            ATT: begin
              m_lvl[i] = (m_lvl[i] + as > amp) ? amp : m_lvl[i] + as;
              if (m_lvl[i] == amp) m_st[i] = SUS;
            end
            SUS: m_lvl[i] = amp;
            REL: begin
              m_lvl[i] = (m_lvl[i] > rs) ? m_lvl[i] - rs : 0;
              if (m_lvl[i] == 0) m_st[i] = IDLE;
            end
            default: m_lvl[i] = 0;
          endcase
        end
      end
    end
    n_edges++;
  end

  always begin : compare
    longint exp_mask;
    @(posedge clk);
    #1;
    exp_mask = 0;
    for (int i = 0; i < NV; i++) if (m_st[i] != IDLE) exp_mask |= (64'd1 << i);
    check("ev_ready", longint'(ev_ready), (reset && !m_pend) ? 1 : 0);
    check("active_mask", longint'(active_mask), exp_mask);
    check("wave_out", longint'($signed(wave_out)), m_wave);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit on, input logic [6:0] k, input logic [HALF_W-1:0] h);
    int guard;
    guard = 0;
    while (!ev_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready", longint'(ev_ready), 1);
    ev_valid = 1'b1; ev_on = on; ev_key = k; ev_half_period = h;
    @(negedge clk);
    ev_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int acc;
    tick(3);
    check("reset_mask", longint'(active_mask), 0);
    check("reset_wave", longint'($signed(wave_out)), 0);
    check("reset_ready", longint'(ev_ready), 0);
    reset = 1'b1;
    tick(1);
    check("ready_after_reset", longint'(ev_ready), 1);

    // Basic note: ramps 25/clk to 100, square of half-period 4.
    amplitude = 31'd100; attack_step = 31'd25; release_step = 31'd50;
    send(1'b1, 7'h41, 16'd4);
    tick(1);  check("basic_mask", longint'(active_mask), 1);
    tick(5);  check("basic_neg", longint'($signed(wave_out)), -100);
    tick(4);  check("basic_pos", longint'($signed(wave_out)), 100);

    // Release: unmatched note-off is a no-op, matched one empties the voice in two steps.
    send(1'b0, 7'h22, 16'd0);
    tick(3);  check("off_unmatched_mask", longint'(active_mask), 1);
    send(1'b0, 7'h41, 16'd0);
    tick(2);  check("release_mid_mask", longint'(active_mask), 1);
    tick(1);  check("release_done_mask", longint'(active_mask), 0);

    // Polyphony and stealing: voices 2/3 hold +1000 each, 0/1 are silent until stolen.
    do_reset();
    amplitude = 31'd1000; attack_step = 31'd100; release_step = 31'd10;
    send(1'b1, 7'd10, 16'd0);
    send(1'b1, 7'd11, 16'd0);
    send(1'b1, 7'd12, 16'd1000);
    send(1'b1, 7'd13, 16'd1000);
    tick(15);
    check("poly_mask", longint'(active_mask), 15);
    check("poly_wave", longint'($signed(wave_out)), 2000);
    send(1'b1, 7'd14, 16'd100);
    tick(3);  check("steal_v0_wave", longint'($signed(wave_out)), 2100);
    check("steal_mask", longint'(active_mask), 15);
    send(1'b1, 7'd15, 16'd100);
    tick(3);  check("steal_v1_wave", longint'($signed(wave_out)), 2600);

    // Saturation: four full-scale voices, near enough in phase.
    do_reset();
    amplitude = 31'h7FFFFFFF; attack_step = 31'h7FFFFFFF;
    send(1'b1, 7'd1, 16'd20);
    send(1'b1, 7'd2, 16'd20);
    send(1'b1, 7'd3, 16'd20);
    send(1'b1, 7'd4, 16'd20);
    tick(4);  check("sat_pos", longint'($signed(wave_out)), MAXP);
    tick(21); check("sat_neg", longint'($signed(wave_out)), MINN);

    // Handshake with ev_valid held high.
    do_reset();
    amplitude = 31'd50; attack_step = 31'd5; release_step = 31'd5;
    ev_valid = 1'b1; ev_on = 1'b0; ev_key = 7'd99; ev_half_period = 16'd0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      check("hs_ready", longint'(ev_ready), (i % 2 == 0) ? 1 : 0);
      if (ev_ready) acc++;
      @(negedge clk);
    end
    ev_valid = 1'b0;
    check("hs_accepts", acc, 5);

    // Reset in the middle of an attack, with an event in flight.
    amplitude = 31'd1000; attack_step = 31'd10;
    send(1'b1, 7'd5, 16'd3);
    tick(5);
    reset = 1'b0; ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd6;
    tick(1);
    check("midrst_mask", longint'(active_mask), 0);
    check("midrst_wave", longint'($signed(wave_out)), 0);
    check("midrst_ready", longint'(ev_ready), 0);
    tick(2);
    check("midrst_ready_hold", longint'(ev_ready), 0);
    reset = 1'b1; ev_valid = 1'b0;
    #1;
    check("midrst_ready_release", longint'(ev_ready), 1);
    tick(1);

    // Randomized traffic over a small key set so retriggers and note-offs collide.
    amplitude = 31'd1500; attack_step = 31'd200; release_step = 31'd150;
    for (int c = 0; c < 3000; c++) begin
      ev_valid       = ($urandom % 3) == 0;
      ev_on          = ($urandom % 3) != 0;
      ev_key         = 7'($urandom % 6);
      ev_half_period = 16'($urandom % 9);
      if ($urandom % 40 == 0) begin
        if ($urandom % 4 == 0) amplitude = 31'($urandom);
        else                   amplitude = 31'($urandom % 2000);
      end
      if ($urandom % 60 == 0) attack_step  = ($urandom % 5 == 0) ? 31'($urandom) : 31'($urandom % 300);
      if ($urandom % 60 == 0) release_step = ($urandom % 8 == 0) ? 31'd0 : 31'($urandom % 300);
      reset = ($urandom % 500) != 0;
      @(negedge clk);
    end
    reset = 1'b1; ev_valid = 1'b0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/poly_voice_controller.md
# poly_voice_controller

Polyphonic successor to the single-note ALU controller. It accepts note-on/note-off events over a valid/ready handshake and allocates them to `NUM_VOICES` independent square-wave voices. Each voice has a linear attack/release envelope. The voice outputs are mixed with saturation into one signed sample that feeds the audio output path.

## Interface
- `NUM_VOICES`, default 4: number of simultaneous voices; must be at least 1.
- `AMP_W`, default 31: width of amplitude, envelope level and step values (unsigned).
- `HALF_W`, default 16: width of the half-period count, in clocks.
- `OUT_W`, default 32: width of the signed mixed output.
- `clk` in, 1: clock.
- `reset` in, 1: synchronous, active-low.
- `ev_valid` in, 1: an event is presented.
- `ev_ready` out, 1: the controller can accept an event.
- `ev_on` in, 1: 1 means note-on, 0 means note-off.
- `ev_key` in, 7: note identity, `{octave[2:0], note[3:0]}`.
- `ev_half_period` in, `HALF_W`: square half-period in clocks; used only on note-on.
- `amplitude` in, `AMP_W`: peak level for the envelope; sampled continuously.
- `attack_step` in, `AMP_W`: level increment per clock during ATTACK.
- `release_step` in, `AMP_W`: level decrement per clock during RELEASE.
- `active_mask` out, `NUM_VOICES`: bit i is 1 when voice i is not IDLE.
- `wave_out` out, `OUT_W`: signed, saturated mix.

## Operation
- **Event FSM states.**
  - S_WAIT: `ev_ready`=1. When `ev_valid` is also 1, the event is latched and the FSM moves to S_APPLY.
  - S_APPLY: `ev_ready`=0. The latched event is applied to the voices, then the FSM returns to S_WAIT.
  - Throughput is one event per 2 clocks.
- **Note-on allocation**, evaluated in S_APPLY, first match wins:
  1. Any non-IDLE voice with an equal key is retriggered: it goes to ATTACK and keeps its current level.
  2. Otherwise the lowest-index IDLE voice is used.
  3. Otherwise the voice at `steal_ptr` is stolen, and `steal_ptr` increments modulo `NUM_VOICES`.
  - The chosen voice loads the key and half-period, clears its phase counter, sets polarity to +, and enters ATTACK. A stolen voice's level restarts at 0.
- **Note-off.** Every voice in ATTACK or SUSTAIN whose key matches goes to RELEASE. If nothing matches, the event is consumed with no effect.
- **Voice states.**
  - IDLE: level is 0.
  - ATTACK: level becomes min(level + `attack_step`, `amplitude`). When level reaches `amplitude`, the voice goes to SUSTAIN.
  - SUSTAIN: level tracks `amplitude`.
  - RELEASE: level becomes max(level − `release_step`, 0). When level reaches 0, the voice goes to IDLE.
  - A step of 0 stalls the envelope. This is legal.
- **Square generation.**
  - The phase counter counts 0 .. half_period−1; on wrap it toggles polarity.
  - The voice sample is +level or −level as a signed value of width `AMP_W`+1.
  - A half-period of 0 forces the voice sample to 0; the envelope still runs.
- **Mix.** Voice samples are summed at width `AMP_W`+1+clog2(`NUM_VOICES`). The sum is saturated to the signed `OUT_W` range and registered.

## Timing
- **Reset** (with `reset`=0 at a clock edge):
  - FSM goes to S_WAIT; `ev_ready` is forced to 0 while `reset`=0.
  - All voices go IDLE with level 0, phase 0 and polarity +.
  - `steal_ptr` = 0, `active_mask` = 0, `wave_out` = 0.
  - An event in flight is discarded.
- **Event latency.** For an event accepted at edge t:
  - the voice state and `active_mask` change at edge t+1;
  - the first envelope step is applied at edge t+2;
  - `wave_out` reflects it at edge t+3.
- `active_mask` and `wave_out` are registered outputs.
- Simultaneous note-off and end of release on the same voice: the voice goes to IDLE.
- Simultaneous note-on retrigger and end of release on the same voice: the retrigger wins and the voice goes to ATTACK.
- If `amplitude` drops below level during ATTACK or SUSTAIN, level is clamped to `amplitude` on the next clock.

## Structure
- Package `synth_pkg` holds:
  - the voice state enum (IDLE, ATTACK, SUSTAIN, RELEASE);
  - the event FSM enum;
  - `KEY_W` = 7;
  - a saturate function for the mix.
- Sub-module `synth_voice` is instantiated `NUM_VOICES` times via generate. It owns the envelope, phase counter and state, and takes load/release strobes from the allocator.
- Allocation, `steal_ptr` and the mixer stay in the top level.

## Test plan
- **Basic note:** after reset, note-on key 0x41, half_period 4, amplitude 100, attack_step 25. Expect `active_mask`=0001; level reaches 100 after 4 envelope clocks; `wave_out` toggles between +100 and −100 every 4 clocks.
- **Polyphony:** 4 distinct note-ons then a 5th. Expect `active_mask`=1111; the 5th steals voice 0, the next one steals voice 1.
- **Release:** note-off on a matching key with release_step 50 from level 100. Expect that voice IDLE after 2 clocks and its `active_mask` bit clears. A note-off with an unmatched key changes nothing.
- **Saturation:** NUM_VOICES=4, AMP_W=31, OUT_W=32, all voices at maximum level and in phase. Expect `wave_out` = 0x7FFFFFFF, then 0x80000000.
- **Handshake and reset:** hold `ev_valid` high continuously. Expect `ev_ready` toggling 1,0,1,0 and exactly one event per 2 clocks. Assert reset mid-attack: all outputs 0 next clock and `ev_ready`=0 until reset deasserts.
